// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: default address width, reset PC, opcode length classes.
// Latency: none (constants and a pure helper function only).
// Backpressure: not applicable.
package cpu_pkg;

    // Default program address width; fetch addresses wrap modulo 2^CPU_ADDR_W.
    localparam int CPU_ADDR_W   = 16;

    // First fetch address after reset.
    localparam int CPU_RESET_PC = 0;

    // Instruction lengths seen by the decode stage.
    localparam int INSN_LEN_1 = 1;
    localparam int INSN_LEN_2 = 2;
    localparam int INSN_LEN_3 = 3;

    // Opcodes whose low nibble is 0xE or 0xF are complete in a single byte.
    localparam logic [3:0] OP1_NIB_LO = 4'hE;
    localparam logic [3:0] OP1_NIB_HI = 4'hF;

    function automatic logic is_one_byte_op(input logic [7:0] opcode);
        return (opcode[3:0] == OP1_NIB_LO) || (opcode[3:0] == OP1_NIB_HI);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small queue of {pc, byte} entries for the prefetch stage; head is a registered read.
// Latency: a push is visible at head_o the cycle after the push edge.
// Backpressure: none internally; the caller never pushes into a full queue without a same-cycle pop.
//
// Ports: clk_i/reset_i (sync, active-high), push_i + push_dat_i, pop_i, flush_i
//        (priority over push/pop), count_o (0..DEPTH), head_o (oldest entry).
module byte_fifo
    import cpu_pkg::*;
#(
    parameter  int WIDTH = 8 + CPU_ADDR_W,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_i && !push_i) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: count_q alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (count_q <= CNT_W'(DEPTH));
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/cpu_prefetch.sv
// Instruction-byte prefetch: reads program memory ahead of the CPU and queues {pc, byte}.
// Latency: read issued in cycle N gives byte_valid in cycle N+2; a jump's first byte is valid 2 cycles later.
// Backpressure: stops issuing when queued + in-flight bytes reach DEPTH; resumes the cycle after a pop.
//
// Ports: clk, reset (sync, active-high); mem_rd_en/mem_addr/mem_rdata to 1-cycle program memory;
//        byte_valid/byte_data/byte_pc/byte_take to the CPU; jump_en/jump_addr redirect.
module cpu_prefetch
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic [ADDR_W-1:0] byte_pc,
    input  logic              byte_take,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = 8 + ADDR_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] pend_pc_q,  pend_pc_d;   // address of the read in flight
    logic              pending_q,  pending_d;

    logic [CNT_W-1:0]  count;
    logic [ENT_W-1:0]  head;
    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              push;
    logic              pop;

    always_comb begin
        // Slots already committed: queued bytes plus the read whose data returns this cycle.
        occupancy  = {1'b0, count} + (CNT_W + 1)'(pending_q);
        issue      = occupancy < (CNT_W + 1)'(DEPTH);

        // A jump always issues, because it empties the queue and cancels the in-flight read.
        mem_rd_en  = !reset && (jump_en || issue);
        mem_addr   = jump_en ? jump_addr : fetch_pc_q;

        // A jump cancels the returning read and ignores a same-cycle take.
        push       = pending_q && !jump_en;
        pop        = byte_take && byte_valid && !jump_en;

        byte_valid = (count != '0);
        byte_data  = head[7:0];
        byte_pc    = head[ENT_W-1:8];

        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        pending_d  = 1'b0;
        if (mem_rd_en) begin
            fetch_pc_d = mem_addr + ADDR_W'(1);
            pend_pc_d  = mem_addr;
            pending_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= RESET_PC;
            pending_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            pending_q  <= pending_d;
        end
    end

    byte_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_byte_fifo (
        .clk_i      (clk),
        .reset_i    (reset),
        .push_i     (push),
        .push_dat_i ({pend_pc_q, mem_rdata}),
        .pop_i      (pop),
        .flush_i    (jump_en),
        .count_o    (count),
        .head_o     (head)
    );

endmodule

// File: tb/tb_cpu_prefetch.sv
module tb_cpu_prefetch;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic [ADDR_W-1:0] byte_pc;
    logic              byte_take = 1'b0;
    logic              jump_en = 1'b0;
    logic [ADDR_W-1:0] jump_addr = '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] prog [65536];

    always #5 clk = ~clk;

    // Program memory: synchronous read, data one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= prog[mem_addr];
    end

    cpu_prefetch #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (16'h0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_pc    (byte_pc),
        .byte_take  (byte_take),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr)
    );

    // Holds reset for two edges; returns at the negedge that starts cycle 0 with reset low.
    task automatic apply_reset();
        reset = 1'b1; jump_en = 1'b0; jump_addr = '0; byte_take = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; jump_en = 1'b0; byte_take = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({byte_valid, mem_rd_en} !== 2'b00) begin
                n_fail++; $display("FAIL reset_outputs: valid/rd_en=%b want 00", {byte_valid, mem_rd_en});
            end
        end
        @(negedge clk); reset = 1'b0; #1;
        n_checks++;
        if ({mem_rd_en, mem_addr} !== {1'b1, 16'h0000}) begin
            n_fail++; $display("FAIL reset_first_read: rd_en=%b addr=%h want 1 0000", mem_rd_en, mem_addr);
        end
    endtask

    task automatic test_fill_stream();
        logic [15:0] e;
        prog[0] = 8'h0C; prog[1] = 8'h0A; prog[2] = 8'h1C; prog[3] = 8'h14;
        apply_reset();
        byte_take = 1'b1; #1;
        for (int k = 0; k < 12; k++) begin
            e = 16'(k - 2);
            n_checks++;
            if (byte_valid !== (k >= 2)) begin
                n_fail++; $display("FAIL stream_valid c%0d: got %b want %b", k, byte_valid, (k >= 2));
            end
            if (k >= 2) begin
                n_checks++;
                if ({byte_pc, byte_data} !== {e, prog[e]}) begin
                    n_fail++; $display("FAIL stream_byte c%0d: pc=%h data=%h want %h %h", k, byte_pc, byte_data, e, prog[e]);
                end
            end
            @(negedge clk); #1;
        end
        byte_take = 1'b0;
    endtask

    task automatic test_fill_stall();
        int n_reads = 0;
        apply_reset();
        byte_take = 1'b0; #1;
        for (int k = 0; k < 10; k++) begin
            if (mem_rd_en) begin
                n_checks++;
                if (mem_addr !== 16'(n_reads)) begin
                    n_fail++; $display("FAIL stall_addr: got %h want %h", mem_addr, 16'(n_reads));
                end
                n_reads++;
            end
            @(negedge clk); #1;
        end
        n_checks++;
        if (n_reads != 4) begin
            n_fail++; $display("FAIL stall_read_count: got %0d want 4", n_reads);
        end
        n_checks++;
        if ({byte_valid, byte_pc} !== {1'b1, 16'h0000}) begin
            n_fail++; $display("FAIL stall_head: valid=%b pc=%h want 1 0000", byte_valid, byte_pc);
        end
        byte_take = 1'b1;
        @(negedge clk); byte_take = 1'b0; #1;
        n_checks++;
        if ({mem_rd_en, mem_addr} !== {1'b1, 16'h0004}) begin
            n_fail++; $display("FAIL take_refill: rd_en=%b addr=%h want 1 0004", mem_rd_en, mem_addr);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({mem_rd_en, byte_pc} !== {1'b0, 16'h0001}) begin
                n_fail++; $display("FAIL refill_full: rd_en=%b pc=%h want 0 0001", mem_rd_en, byte_pc);
            end
        end
        byte_take = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if ({byte_valid, byte_pc} !== {1'b1, 16'(1 + j)}) begin
                n_fail++; $display("FAIL refill_drain: valid=%b pc=%h want 1 %h", byte_valid, byte_pc, 16'(1 + j));
            end
            @(negedge clk); #1;
        end
        byte_take = 1'b0;
    endtask

    task automatic test_jump_flush();
        apply_reset();
        byte_take = 1'b0;
        repeat (6) @(negedge clk);
        byte_take = 1'b1;
        repeat (5) @(negedge clk);
        byte_take = 1'b0;
        @(negedge clk); #1;
        // Queue now holds 5..7 with the read of 8 in flight.
        n_checks++;
        if ({byte_valid, byte_pc, mem_rd_en} !== {1'b1, 16'h0005, 1'b0}) begin
            n_fail++; $display("FAIL jump_setup: valid=%b pc=%h rd_en=%b want 1 0005 0", byte_valid, byte_pc, mem_rd_en);
        end
        jump_en = 1'b1; jump_addr = 16'h0002; byte_take = 1'b1; #1;
        n_checks++;
        if ({mem_rd_en, mem_addr} !== {1'b1, 16'h0002}) begin
            n_fail++; $display("FAIL jump_issue: rd_en=%b addr=%h want 1 0002", mem_rd_en, mem_addr);
        end
        @(negedge clk); jump_en = 1'b0; byte_take = 1'b0; #1;
        n_checks++;
        if (byte_valid !== 1'b0) begin
            n_fail++; $display("FAIL jump_flush: valid=%b want 0", byte_valid);
        end
        @(negedge clk); byte_take = 1'b1; #1;
        for (int j = 0; j < 7; j++) begin
            n_checks++;
            if ({byte_valid, byte_pc, byte_data} !== {1'b1, 16'(2 + j), prog[2 + j]}) begin
                n_fail++; $display("FAIL jump_stream: valid=%b pc=%h data=%h want 1 %h %h", byte_valid, byte_pc, byte_data, 16'(2 + j), prog[2 + j]);
            end
            @(negedge clk); #1;
        end
        byte_take = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        apply_reset();
        repeat (3) @(negedge clk);
        jump_en = 1'b1; jump_addr = 16'h0010; #1;
        n_checks++;
        if ({mem_rd_en, mem_addr} !== {1'b1, 16'h0010}) begin
            n_fail++; $display("FAIL b2b_first: rd_en=%b addr=%h want 1 0010", mem_rd_en, mem_addr);
        end
        @(negedge clk); jump_addr = 16'h0020; #1;
        n_checks++;
        if ({mem_rd_en, mem_addr, byte_valid} !== {1'b1, 16'h0020, 1'b0}) begin
            n_fail++; $display("FAIL b2b_second: rd_en=%b addr=%h valid=%b want 1 0020 0", mem_rd_en, mem_addr, byte_valid);
        end
        @(negedge clk); jump_en = 1'b0; byte_take = 1'b1; #1;
        n_checks++;
        if (byte_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_gap: valid=%b want 0", byte_valid);
        end
        @(negedge clk); #1;
        for (int j = 0; j < 6; j++) begin
            e = 16'h0020 + 16'(j);
            n_checks++;
            if ({byte_valid, byte_pc, byte_data} !== {1'b1, e, prog[e]}) begin
                n_fail++; $display("FAIL b2b_stream: valid=%b pc=%h data=%h want 1 %h %h", byte_valid, byte_pc, byte_data, e, prog[e]);
            end
            @(negedge clk); #1;
        end
        byte_take = 1'b0;
    endtask

    task automatic test_wrap();
        logic [15:0] e;
        apply_reset();
        byte_take = 1'b1;
        repeat (3) @(negedge clk);
        jump_en = 1'b1; jump_addr = 16'hFFFF;
        @(negedge clk); jump_en = 1'b0;
        @(negedge clk); #1;
        for (int j = 0; j < 4; j++) begin
            e = 16'hFFFF + 16'(j);
            n_checks++;
            if ({byte_valid, byte_pc, byte_data} !== {1'b1, e, prog[e]}) begin
                n_fail++; $display("FAIL wrap_stream: valid=%b pc=%h data=%h want 1 %h %h", byte_valid, byte_pc, byte_data, e, prog[e]);
            end
            @(negedge clk); #1;
        end
        byte_take = 1'b0;
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        byte_take = 1'b0;
        repeat (6) @(negedge clk);
        byte_take = 1'b1;
        @(negedge clk); byte_take = 1'b0;
        @(negedge clk); reset = 1'b1;   // read of 4 is returning this cycle
        @(negedge clk); #1;
        n_checks++;
        if ({byte_valid, mem_rd_en} !== 2'b00) begin
            n_fail++; $display("FAIL midreset_outputs: valid/rd_en=%b want 00", {byte_valid, mem_rd_en});
        end
        @(negedge clk); reset = 1'b0; byte_take = 1'b1; #1;
        n_checks++;
        if ({mem_rd_en, mem_addr} !== {1'b1, 16'h0000}) begin
            n_fail++; $display("FAIL midreset_restart: rd_en=%b addr=%h want 1 0000", mem_rd_en, mem_addr);
        end
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if ({byte_valid, (k >= 2) ? byte_pc : 16'h0000} !== {(k >= 2), 16'(k >= 2 ? k - 2 : 0)}) begin
                n_fail++; $display("FAIL midreset_stream c%0d: valid=%b pc=%h want %b %h", k, byte_valid, byte_pc, (k >= 2), 16'(k >= 2 ? k - 2 : 0));
            end
            @(negedge clk); #1;
        end
        byte_take = 1'b0;
    endtask

    // Random takes and jumps against a stream-level model: the head is always the next
    // expected address, reads go out in address order, and the stage keeps exactly
    // DEPTH bytes committed (issued since the last redirect and not yet consumed).
    task automatic test_random();
        logic [15:0] exp_pc, next_issue, ja;
        int          outstanding, since_jump;
        logic        jmp, tk, exp_rd;
        apply_reset();
        exp_pc = 16'h0000; next_issue = 16'h0000; outstanding = 0; since_jump = 100;
        for (int c = 0; c < 400; c++) begin
            jmp = ($urandom_range(0, 24) == 0);
            tk  = ($urandom_range(0, 2) != 0);
            ja  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ja = 16'hFFFC + 16'($urandom_range(0, 3));
            jump_en = jmp; jump_addr = ja; byte_take = tk; #1;
            if (byte_valid) begin
                n_checks++;
                if ({byte_pc, byte_data} !== {exp_pc, prog[exp_pc]}) begin
                    n_fail++; $display("FAIL rand_head c%0d: pc=%h data=%h want %h %h", c, byte_pc, byte_data, exp_pc, prog[exp_pc]);
                end
            end
            if (since_jump == 1 || since_jump == 2) begin
                n_checks++;
                if (byte_valid !== (since_jump == 2)) begin
                    n_fail++; $display("FAIL rand_jump_latency c%0d: valid=%b want %b", c, byte_valid, (since_jump == 2));
                end
            end
            exp_rd = jmp || (outstanding < DEPTH);
            n_checks++;
            if (mem_rd_en !== exp_rd) begin
                n_fail++; $display("FAIL rand_issue c%0d: rd_en=%b want %b", c, mem_rd_en, exp_rd);
            end
            if (mem_rd_en && exp_rd) begin
                n_checks++;
                if (mem_addr !== (jmp ? ja : next_issue)) begin
                    n_fail++; $display("FAIL rand_addr c%0d: addr=%h want %h", c, mem_addr, jmp ? ja : next_issue);
                end
            end
            if (jmp) begin
                outstanding = 1; next_issue = ja + 16'h1; exp_pc = ja; since_jump = 1;
            end else begin
                if (exp_rd) begin
                    outstanding++; next_issue = next_issue + 16'h1;
                end
                if (tk && byte_valid) begin
                    outstanding--; exp_pc = exp_pc + 16'h1;
                end
                if (since_jump < 100) since_jump++;
            end
            @(negedge clk);
        end
        jump_en = 1'b0; byte_take = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) prog[i] = 8'($urandom);
        test_reset();
        test_fill_stream();
        test_fill_stall();
        test_jump_flush();
        test_back_to_back();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
